// File: rtl/program_loader_if.sv
// Bundles the loader's byte-stream, CPU memory port, RAM port and status signals.
// slave = loader side, master = surrounding system (receiver, CPU, RAM).
interface program_loader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reload;
  logic [15:0]       cpu_addr;
  logic              cpu_memwrite;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport slave (
    input  rx_data, rx_valid, reload, cpu_addr, cpu_memwrite, cpu_wdata, mem_rdata,
    output rx_ready, cpu_rdata, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_error
  );

  modport master (
    output rx_data, rx_valid, reload, cpu_addr, cpu_memwrite, cpu_wdata, mem_rdata,
    input  rx_ready, cpu_rdata, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a length-prefixed byte stream into RAM words from address 0, then
// releases the CPU and passes its memory port straight through. Moore outputs, no added latency in RUN.
module program_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.slave   bus
);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  localparam logic [2:0] S_HDR_HI  = 3'd0;
  localparam logic [2:0] S_HDR_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              rx_ready;
  logic              accept;
  logic [16:0]       n_ext;
  logic [PTR_W-1:0]  ptr_inc;
  logic              unused_cpu_addr_hi;

  assign unused_cpu_addr_hi = ^bus.cpu_addr[15:ADDR_W];

  assign rx_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign accept   = rx_ready & bus.rx_valid;
  // Count compared at 17 bits so a full-depth image (N == DEPTH) stays legal.
  assign n_ext    = {1'b0, count_q[15:8], bus.rx_data};
  assign ptr_inc  = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = bus.rx_data;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = bus.rx_data;
          if (n_ext == 17'd0) begin
            state_d = S_RUN;
          end else if (n_ext > DEPTH) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_HI;
            ptr_d   = '0;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          word_d[15:8] = bus.rx_data;
          state_d      = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          word_d[7:0] = bus.rx_data;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        ptr_d = ptr_inc;
        if (17'(ptr_inc) == {1'b0, count_q}) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_RUN: begin
        if (bus.reload) begin
          state_d = S_HDR_HI;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR_HI;
      count_q <= '0;
      word_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
    end
  end

  // RAM port: loader owns it during WRITE, the CPU owns it combinationally in RUN.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == S_WRITE) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = ptr_q[ADDR_W-1:0];
      bus.mem_wdata = word_q;
    end else if (state_q == S_RUN) begin
      bus.mem_we    = bus.cpu_memwrite;
      bus.mem_addr  = bus.cpu_addr[ADDR_W-1:0];
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_hold   = (state_q != S_RUN);
  assign bus.load_done  = (state_q == S_RUN);
  assign bus.load_error = (state_q == S_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: behavioural 1-cycle RAM, byte-stream driver and a write scoreboard.
module tb_program_loader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int w0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0] sb_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every loader write must match the oldest outstanding expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && bus.mem_we && bus.cpu_hold) begin
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = 32'hFFFF_FFFF;
      check("wr", 32'({bus.mem_addr, bus.mem_wdata}), e);
      check("wr_rdy", 32'(bus.rx_ready), 32'd0);
      wr_cnt++;
      last_wr_addr = bus.mem_addr;
    end
  end

  task automatic push_hdr(input logic [15:0] n);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
  endtask

  task automatic push_word(input int addr, input logic [15:0] d);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    tx_q.push_back(d[15:8]);
    tx_q.push_back(d[7:0]);
    sb_q.push_back(32'({a, d}));
  endtask

  task automatic play(input bit hold, input bit gaps);
    while (tx_q.size() > 0) begin
      logic [7:0] b;
      int guard;
      b = tx_q.pop_front();
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.rx_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      guard = 0;
      while (!bus.rx_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (!bus.rx_ready) begin
        check("rdy_timeout", 32'(bus.rx_ready), 32'd1);
        tx_q.delete();
        break;
      end
      @(negedge clk);
      if (!hold) bus.rx_valid = 1'b0;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!bus.load_done && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("done", 32'(bus.load_done), 32'd1);
    check("hold_rel", 32'(bus.cpu_hold), 32'd0);
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    check("rl_hold", 32'(bus.cpu_hold), 32'd1);
    check("rl_rdy", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic chk_reset_outs();
    check("rs_rdy", 32'(bus.rx_ready), 32'd1);
    check("rs_we", 32'(bus.mem_we), 32'd0);
    check("rs_addr", 32'(bus.mem_addr), 32'd0);
    check("rs_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rs_hold", 32'(bus.cpu_hold), 32'd1);
    check("rs_done", 32'(bus.load_done), 32'd0);
    check("rs_err", 32'(bus.load_error), 32'd0);
  endtask

  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.reload = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_memwrite = 1'b0;
    bus.cpu_wdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load
    w0 = wr_cnt;
    push_hdr(16'd2);
    push_word(0, 16'h1234);
    push_word(1, 16'hABCD);
    play(1'b0, 1'b0);
    wait_done();
    check("t1_wrcnt", 32'(wr_cnt - w0), 32'd2);
    check("t1_sb", 32'(sb_q.size()), 32'd0);
    check("t1_ram0", 32'(ram[0]), 32'h1234);
    check("t1_ram1", 32'(ram[1]), 32'hABCD);

    // CPU pass-through in RUN
    bus.cpu_addr = 16'hC005;
    bus.cpu_memwrite = 1'b1;
    bus.cpu_wdata = 16'h5555;
    #1;
    check("pt_addr", 32'(bus.mem_addr), 32'h0005);
    check("pt_we", 32'(bus.mem_we), 32'd1);
    check("pt_wdata", 32'(bus.mem_wdata), 32'h5555);
    @(negedge clk);
    bus.cpu_memwrite = 1'b0;
    bus.cpu_addr = 16'h0005;
    @(negedge clk);
    check("pt_rd5", 32'(bus.cpu_rdata), 32'h5555);
    bus.cpu_addr = 16'h0000;
    @(negedge clk);
    check("pt_rd0", 32'(bus.cpu_rdata), 32'h1234);

    // Reload keeps other RAM words
    do_reload();
    w0 = wr_cnt;
    push_hdr(16'd1);
    push_word(0, 16'h0007);
    play(1'b0, 1'b0);
    wait_done();
    check("t6_ram0", 32'(ram[0]), 32'h0007);
    check("t6_ram1", 32'(ram[1]), 32'hABCD);
    check("t6_wrcnt", 32'(wr_cnt - w0), 32'd1);

    // Zero-length image
    do_reload();
    w0 = wr_cnt;
    push_hdr(16'd0);
    play(1'b0, 1'b0);
    check("n0_done", 32'(bus.load_done), 32'd1);
    check("n0_wrcnt", 32'(wr_cnt - w0), 32'd0);

    // rx_valid held high through WRITE, then random gaps
    for (int pass = 0; pass < 2; pass++) begin
      do_reload();
      w0 = wr_cnt;
      push_hdr(16'd3);
      push_word(0, 16'hA1B2);
      push_word(1, 16'hC3D4);
      push_word(2, 16'hE5F6);
      play(pass == 0, pass == 1);
      wait_done();
      check("t3_wrcnt", 32'(wr_cnt - w0), 32'd3);
      check("t3_sb", 32'(sb_q.size()), 32'd0);
      check("t3_ram0", 32'(ram[0]), 32'hA1B2);
      check("t3_ram1", 32'(ram[1]), 32'hC3D4);
      check("t3_ram2", 32'(ram[2]), 32'hE5F6);
    end

    // Async reset mid-word discards the partial word
    do_reload();
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h55);
    play(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_hdr(16'd1);
    push_word(0, 16'hBEEF);
    play(1'b0, 1'b0);
    wait_done();
    check("t5_ram0", 32'(ram[0]), 32'hBEEF);
    check("t5_sb", 32'(sb_q.size()), 32'd0);

    // Async reset out of RUN
    #2 rst_n = 1'b0;
    #1 check("arst_done", 32'(bus.load_done), 32'd0);
    check("arst_hold", 32'(bus.cpu_hold), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-depth image
    w0 = wr_cnt;
    push_hdr(16'h4000);
    for (int i = 0; i < DEPTH; i++) push_word(i, 16'(i * 37 + 5));
    play(1'b1, 1'b0);
    wait_done();
    check("max_wrcnt", 32'(wr_cnt - w0), 32'(DEPTH));
    check("max_last", 32'(last_wr_addr), 32'h3FFF);
    check("max_sb", 32'(sb_q.size()), 32'd0);
    check("max_ram_last", 32'(ram[DEPTH-1]), 32'(16'((DEPTH - 1) * 37 + 5)));

    // Oversized count is a sticky error
    do_reload();
    w0 = wr_cnt;
    push_hdr(16'h4001);
    play(1'b0, 1'b0);
    check("err_flag", 32'(bus.load_error), 32'd1);
    check("err_rdy", 32'(bus.rx_ready), 32'd0);
    check("err_hold", 32'(bus.cpu_hold), 32'd1);
    bus.reload = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h00;
    repeat (5) @(negedge clk);
    bus.reload = 1'b0;
    bus.rx_valid = 1'b0;
    check("err_sticky", 32'(bus.load_error), 32'd1);
    check("err_done", 32'(bus.load_done), 32'd0);
    check("err_wrcnt", 32'(wr_cnt - w0), 32'd0);
    rst_n = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
